// File: rtl/ldpc_job_sched_if.sv
// Bit-buffer and run-control bus between the job scheduler (master) and the
// ldpcEncDec coder datapath (slave).
interface ldpc_job_sched_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] core_addr_o;
  logic              core_we_o;
  logic              core_wbit_o;
  logic              core_rbit_i;
  logic              core_mode_o;
  logic              core_start_o;
  logic              core_done_i;
  logic              core_err_i;
  logic [ADDR_W-1:0] core_olen_i;

  modport master (
    output core_addr_o, core_we_o, core_wbit_o, core_mode_o, core_start_o,
    input  core_rbit_i, core_done_i, core_err_i, core_olen_i
  );

  modport slave (
    input  core_addr_o, core_we_o, core_wbit_o, core_mode_o, core_start_o,
    output core_rbit_i, core_done_i, core_err_i, core_olen_i
  );
endinterface

// File: rtl/ldpc_job_sched.sv
// Round-robin job scheduler sharing one ldpcEncDec core between the Wishbone
// front end (requester 0) and the GPIO serial front end (requester 1).
module ldpc_job_sched #(
  parameter int ADDR_W = 16,
  parameter int TMO_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        req_mode_i,
  input  logic [ADDR_W-1:0] req_len0_i,
  input  logic [ADDR_W-1:0] req_len1_i,
  input  logic [1:0]        src_vld_i,
  input  logic [1:0]        src_bit_i,
  output logic [1:0]        src_rd_o,
  output logic [1:0]        snk_vld_o,
  output logic              snk_bit_o,
  output logic [1:0]        gnt_o,
  output logic [1:0]        ack_o,
  output logic              err_o,
  ldpc_job_sched_if.master  core
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_UNLOAD = 3'd3,
    S_ACK    = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] A_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  T_ONE    = {{(TMO_W-1){1'b0}}, 1'b1};
  // Last count value before the counter would reach 2^TMO_W-1.
  localparam logic [TMO_W-1:0]  TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [1:0]        snk_vld_q, snk_vld_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] olen_q, olen_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic sel_s;
  logic req_g_s;
  logic vld_g_s;
  logic bit_g_s;
  logic wr_s;

  assign sel_s   = (req_i == 2'b11) ? ~last_q : req_i[1];
  assign req_g_s = |(req_i & gnt_q);
  assign vld_g_s = |(src_vld_i & gnt_q);
  assign bit_g_s = |(src_bit_i & gnt_q);

  // State and datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      last_q    <= 1'b1;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      snk_vld_q <= 2'b00;
      len_q     <= '0;
      cnt_q     <= '0;
      olen_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      start_q   <= start_d;
      snk_vld_q <= snk_vld_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      olen_q    <= olen_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state logic; a dropped grantee request wins over any advance.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    mode_d    = mode_q;
    err_d     = err_q;
    start_d   = 1'b0;
    snk_vld_d = 2'b00;
    len_d     = len_q;
    cnt_d     = cnt_q;
    olen_d    = olen_q;
    tmo_d     = tmo_q;
    wr_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          gnt_d  = sel_s ? 2'b10 : 2'b01;
          last_d = sel_s;
          mode_d = req_mode_i[sel_s];
          len_d  = sel_s ? req_len1_i : req_len0_i;
          cnt_d  = '0;
          tmo_d  = '0;
          err_d  = 1'b0;
          if (len_d == '0) begin
            state_d = S_RUN;
            start_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!req_g_s) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          cnt_d   = '0;
        end else if (vld_g_s) begin
          wr_s = 1'b1;
          if (cnt_q == len_q - A_ONE) begin
            cnt_d   = '0;
            tmo_d   = '0;
            start_d = 1'b1;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + A_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        if (!req_g_s) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
        end else if (core.core_done_i) begin
          if (core.core_err_i) begin
            err_d   = 1'b1;
            state_d = S_ACK;
          end else if (core.core_olen_i == '0) begin
            state_d = S_ACK;
          end else begin
            olen_d  = core.core_olen_i;
            cnt_d   = '0;
            state_d = S_UNLOAD;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          tmo_d = tmo_q + T_ONE;
        end
      end
      S_UNLOAD: begin
        // cnt_q == olen_q is the drain cycle that presents the last bit.
        if (!req_g_s) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          cnt_d   = '0;
        end else if (cnt_q == olen_q) begin
          state_d = S_ACK;
        end else begin
          snk_vld_d = gnt_q;
          cnt_d     = cnt_q + A_ONE;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  assign src_rd_o          = wr_s ? gnt_q : 2'b00;
  assign core.core_we_o    = wr_s;
  assign core.core_wbit_o  = wr_s & bit_g_s;
  assign core.core_addr_o  = cnt_q;
  assign core.core_mode_o  = mode_q;
  assign core.core_start_o = start_q;
  assign gnt_o             = gnt_q;
  assign snk_vld_o         = snk_vld_q;
  assign snk_bit_o         = (|snk_vld_q) & core.core_rbit_i;
  assign ack_o             = (state_q == S_ACK) ? gnt_q : 2'b00;
  assign err_o             = (state_q == S_ACK) & err_q;

endmodule

// File: tb/tb_ldpc_job_sched.sv
// Directed bench for ldpc_job_sched: main DUT plus a TMO_W=4 instance for timeout.
module tb_ldpc_job_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00, t_req = 2'b00, mode = 2'b00, vld = 2'b00, sbit = 2'b00;
    logic [15:0] len0 = 16'd0, len1 = 16'd0, olen = 16'd0;
    logic        done = 1'b0, cerr = 1'b0;
    logic [1:0]  src_rd, snk_vld, gnt, ack, t_src_rd, t_snk_vld, t_gnt, t_ack;
    logic        snk_bit, err, t_snk_bit, t_err;
    logic        mem [0:63];
    logic [7:0]  din = 8'b01001101;
    logic [11:0] dout = 12'b001001001101;
    int          checks = 0, errs = 0;

    ldpc_job_sched_if #(.ADDR_W(16)) bus ();
    ldpc_job_sched_if #(.ADDR_W(16)) t_bus ();

    ldpc_job_sched #(.ADDR_W(16), .TMO_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req_i(req), .req_mode_i(mode),
        .req_len0_i(len0), .req_len1_i(len1), .src_vld_i(vld), .src_bit_i(sbit),
        .src_rd_o(src_rd), .snk_vld_o(snk_vld), .snk_bit_o(snk_bit), .gnt_o(gnt),
        .ack_o(ack), .err_o(err), .core(bus)
    );

    ldpc_job_sched #(.ADDR_W(16), .TMO_W(4)) dut_t (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req_i(t_req), .req_mode_i(mode),
        .req_len0_i(len0), .req_len1_i(len1), .src_vld_i(vld), .src_bit_i(sbit),
        .src_rd_o(t_src_rd), .snk_vld_o(t_snk_vld), .snk_bit_o(t_snk_bit), .gnt_o(t_gnt),
        .ack_o(t_ack), .err_o(t_err), .core(t_bus)
    );

    assign bus.core_done_i   = done;
    assign bus.core_err_i    = cerr;
    assign bus.core_olen_i   = olen;
    assign t_bus.core_done_i = 1'b0;
    assign t_bus.core_err_i  = 1'b0;
    assign t_bus.core_olen_i = 16'd0;
    assign t_bus.core_rbit_i = 1'b0;

    // Clock generator.
    always #5 clk = ~clk;

    // Core buffer: preset pattern on reset, 1-cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i % 3 == 0);
            bus.core_rbit_i <= 1'b0;
        end else begin
            if (bus.core_we_o) mem[bus.core_addr_o[5:0]] <= bus.core_wbit_o;
            bus.core_rbit_i <= mem[bus.core_addr_o[5:0]];
        end
    end

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        errs++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic arb_job(input logic [1:0] g);
        nxt(); #1;
        checks++; if (gnt !== g) fail("arb_gnt", gnt, g);
        checks++; if (src_rd !== g) fail("arb_rd", src_rd, g);
        repeat (3) nxt();
        nxt(); done = 1'b1; olen = 16'd0; #1;
        checks++; if (bus.core_start_o !== 1'b1) fail("arb_start", bus.core_start_o, 1'b1);
        nxt(); done = 1'b0; #1;
        checks++; if (ack !== g) fail("arb_ack", ack, g);
        checks++; if (err !== 1'b0) fail("arb_err", err, 1'b0);
        nxt(); #1;
        checks++; if (gnt !== 2'b00) fail("arb_idle_gap", gnt, 2'b00);
    endtask

    // Directed stimulus and checks.
    initial begin
        #2;
        checks++; if ({gnt, ack, err, snk_vld, snk_bit, src_rd, bus.core_we_o, bus.core_start_o, bus.core_mode_o, bus.core_addr_o} !== 29'd0)
            fail("rst_outputs", {gnt, ack, err, snk_vld, snk_bit, src_rd, bus.core_we_o, bus.core_start_o, bus.core_mode_o, bus.core_addr_o}, 29'd0);
        checks++; if ({t_gnt, t_ack, t_err, t_snk_vld, t_snk_bit, t_src_rd} !== 10'd0)
            fail("rst_outputs_t", {t_gnt, t_ack, t_err, t_snk_vld, t_snk_bit, t_src_rd}, 10'd0);
        #20 rst_n = 1'b1;

        // Encode on requester 0, len 8, done 20 cycles after start, olen 12
        nxt(); req = 2'b01; mode = 2'b01; len0 = 16'd8; #1;
        checks++; if (gnt !== 2'b00) fail("enc_gnt_latency", gnt, 2'b00);
        nxt(); #1;
        checks++; if (gnt !== 2'b01) fail("enc_gnt", gnt, 2'b01);
        checks++; if (bus.core_we_o !== 1'b0) fail("enc_stall_we", bus.core_we_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
            nxt(); vld = 2'b01; sbit = {1'b0, din[i]}; #1;
            checks++; if (src_rd !== 2'b01) fail("enc_rd", src_rd, 2'b01);
            checks++; if (bus.core_we_o !== 1'b1) fail("enc_we", bus.core_we_o, 1'b1);
            checks++; if (bus.core_addr_o !== 16'(i)) fail("enc_addr", bus.core_addr_o, 16'(i));
            checks++; if (bus.core_wbit_o !== din[i]) fail("enc_wbit", bus.core_wbit_o, din[i]);
        end
        nxt(); vld = 2'b00; #1;
        checks++; if (bus.core_start_o !== 1'b1) fail("enc_start", bus.core_start_o, 1'b1);
        checks++; if (bus.core_mode_o !== 1'b1) fail("enc_mode", bus.core_mode_o, 1'b1);
        nxt(); #1;
        checks++; if (bus.core_start_o !== 1'b0) fail("enc_start_pulse", bus.core_start_o, 1'b0);
        repeat (18) nxt();
        nxt(); done = 1'b1; olen = 16'd12; #1;
        checks++; if (snk_vld !== 2'b00) fail("enc_no_snk_run", snk_vld, 2'b00);
        nxt(); done = 1'b0; #1;
        checks++; if (bus.core_addr_o !== 16'd0) fail("enc_unl_addr0", bus.core_addr_o, 16'd0);
        checks++; if (snk_vld !== 2'b00) fail("enc_unl_vld0", snk_vld, 2'b00);
        for (int j = 0; j < 12; j++) begin
            nxt(); #1;
            checks++; if (snk_vld !== 2'b01) fail("enc_snk_vld", snk_vld, 2'b01);
            checks++; if (snk_bit !== dout[j]) fail("enc_snk_bit", snk_bit, dout[j]);
        end
        nxt(); #1;
        checks++; if (ack !== 2'b01) fail("enc_ack", ack, 2'b01);
        checks++; if (err !== 1'b0) fail("enc_err", err, 1'b0);
        checks++; if (snk_vld !== 2'b00) fail("enc_ack_snk", snk_vld, 2'b00);
        req = 2'b00;
        nxt(); #1;
        checks++; if ({gnt, ack} !== 4'b0000) fail("enc_done_idle", {gnt, ack}, 4'b0000);

        // Arbitration from reset: grants 0,1,0
        rst_n = 1'b0; #1; rst_n = 1'b1;
        nxt(); req = 2'b11; vld = 2'b11; mode = 2'b00; len0 = 16'd4; len1 = 16'd4; #1;
        checks++; if (gnt !== 2'b00) fail("arb_first_idle", gnt, 2'b00);
        arb_job(2'b01);
        arb_job(2'b10);
        arb_job(2'b01);
        req = 2'b00;

        // Core error: no unload, ack next cycle with err
        nxt(); req = 2'b01; len0 = 16'd1; vld = 2'b01; #1;
        checks++; if (gnt !== 2'b00) fail("cerr_idle", gnt, 2'b00);
        nxt(); #1;
        checks++; if (gnt !== 2'b01) fail("cerr_gnt", gnt, 2'b01);
        checks++; if (bus.core_we_o !== 1'b1) fail("cerr_we", bus.core_we_o, 1'b1);
        nxt(); #1;
        checks++; if (bus.core_start_o !== 1'b1) fail("cerr_start", bus.core_start_o, 1'b1);
        nxt(); #1;
        nxt(); done = 1'b1; cerr = 1'b1; #1;
        checks++; if (ack !== 2'b00) fail("cerr_ack_early", ack, 2'b00);
        nxt(); done = 1'b0; cerr = 1'b0; #1;
        checks++; if (ack !== 2'b01) fail("cerr_ack", ack, 2'b01);
        checks++; if (err !== 1'b1) fail("cerr_err", err, 1'b1);
        checks++; if (snk_vld !== 2'b00) fail("cerr_no_snk", snk_vld, 2'b00);
        req = 2'b00; vld = 2'b00;
        nxt(); #1;
        checks++; if ({gnt, ack, err, snk_vld} !== 7'd0) fail("cerr_after", {gnt, ack, err, snk_vld}, 7'd0);

        // Abort: requester 1 drops at bit 3 of 8, pending requester 0 follows
        nxt(); req = 2'b10; len1 = 16'd8; vld = 2'b10; sbit = 2'b11; #1;
        nxt(); #1;
        checks++; if (gnt !== 2'b10) fail("abt_gnt", gnt, 2'b10);
        checks++; if (src_rd !== 2'b10) fail("abt_rd", src_rd, 2'b10);
        req = 2'b11; len0 = 16'd3; mode = 2'b01;
        nxt(); #1;
        nxt(); #1;
        checks++; if (bus.core_addr_o !== 16'd2) fail("abt_addr2", bus.core_addr_o, 16'd2);
        nxt(); req = 2'b01; #1;
        checks++; if (src_rd !== 2'b00) fail("abt_no_rd", src_rd, 2'b00);
        checks++; if (bus.core_we_o !== 1'b0) fail("abt_no_we", bus.core_we_o, 1'b0);
        nxt(); #1;
        checks++; if ({gnt, ack} !== 4'b0000) fail("abt_idle", {gnt, ack}, 4'b0000);
        nxt(); #1;
        checks++; if (gnt !== 2'b01) fail("abt_regrant", gnt, 2'b01);
        checks++; if (src_rd !== 2'b00) fail("abt_stall", src_rd, 2'b00);
        for (int i = 0; i < 3; i++) begin
            nxt(); vld = 2'b01; sbit = 2'b00; #1;
            checks++; if (bus.core_addr_o !== 16'(i)) fail("abt_load_addr", bus.core_addr_o, 16'(i));
        end
        nxt(); vld = 2'b00; #1;
        checks++; if (bus.core_start_o !== 1'b1) fail("abt_start", bus.core_start_o, 1'b1);
        nxt(); done = 1'b1; olen = 16'd5; #1;
        nxt(); done = 1'b0; #1;
        checks++; if (bus.core_addr_o !== 16'd0) fail("unl_addr0", bus.core_addr_o, 16'd0);
        nxt(); #1;
        checks++; if (snk_vld !== 2'b01) fail("unl_vld", snk_vld, 2'b01);
        nxt(); #1;
        checks++; if (bus.core_addr_o !== 16'd2) fail("unl_addr2", bus.core_addr_o, 16'd2);

        // Reset mid-UNLOAD, then a len=0 job
        rst_n = 1'b0; #1;
        checks++; if ({gnt, ack, err, snk_vld, snk_bit, src_rd, bus.core_we_o, bus.core_start_o, bus.core_mode_o, bus.core_addr_o} !== 29'd0)
            fail("rst_mid", {gnt, ack, err, snk_vld, snk_bit, src_rd, bus.core_we_o, bus.core_start_o, bus.core_mode_o, bus.core_addr_o}, 29'd0);
        req = 2'b00;
        nxt(); rst_n = 1'b1;
        nxt(); req = 2'b01; len0 = 16'd0; #1;
        checks++; if (gnt !== 2'b00) fail("z_idle", gnt, 2'b00);
        nxt(); #1;
        checks++; if (gnt !== 2'b01) fail("z_gnt", gnt, 2'b01);
        checks++; if (bus.core_start_o !== 1'b1) fail("z_start", bus.core_start_o, 1'b1);
        checks++; if (bus.core_we_o !== 1'b0) fail("z_no_we", bus.core_we_o, 1'b0);
        nxt(); done = 1'b1; olen = 16'd0; #1;
        checks++; if (bus.core_start_o !== 1'b0) fail("z_start_pulse", bus.core_start_o, 1'b0);
        nxt(); done = 1'b0; #1;
        checks++; if (ack !== 2'b01) fail("z_ack", ack, 2'b01);
        checks++; if (err !== 1'b0) fail("z_err", err, 1'b0);
        req = 2'b00;
        nxt(); #1;
        checks++; if (gnt !== 2'b00) fail("z_idle_after", gnt, 2'b00);

        // Timeout on the TMO_W=4 instance
        mode = 2'b00;
        nxt(); t_req = 2'b01; #1;
        nxt(); #1;
        checks++; if (t_gnt !== 2'b01) fail("tmo_gnt", t_gnt, 2'b01);
        checks++; if (t_bus.core_start_o !== 1'b1) fail("tmo_start", t_bus.core_start_o, 1'b1);
        repeat (14) nxt();
        checks++; if (t_ack !== 2'b00) fail("tmo_ack_early", t_ack, 2'b00);
        nxt(); #1;
        checks++; if (t_ack !== 2'b01) fail("tmo_ack", t_ack, 2'b01);
        checks++; if (t_err !== 1'b1) fail("tmo_err", t_err, 1'b1);
        checks++; if ({t_snk_vld, t_snk_bit, t_src_rd} !== 5'd0) fail("tmo_no_snk", {t_snk_vld, t_snk_bit, t_src_rd}, 5'd0);
        checks++; if ({t_bus.core_addr_o, t_bus.core_we_o, t_bus.core_wbit_o, t_bus.core_mode_o} !== 19'd0)
            fail("tmo_bus", {t_bus.core_addr_o, t_bus.core_we_o, t_bus.core_wbit_o, t_bus.core_mode_o}, 19'd0);
        t_req = 2'b00;
        nxt(); #1;
        checks++; if ({t_gnt, t_ack, t_err} !== 5'd0) fail("tmo_idle", {t_gnt, t_ack, t_err}, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
